// File: rtl/wb_gpio_irq_pkg.sv
// Shared constants and types for the GPIO input interrupt controller.
package wb_gpio_irq_pkg;

   // Word index on wb_adr_i[4:2]
   localparam logic [2:0] REG_IN     = 3'd0;
   localparam logic [2:0] REG_MASK   = 3'd1;
   localparam logic [2:0] REG_RISE   = 3'd2;
   localparam logic [2:0] REG_FALL   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   // Cycles the input pipeline needs after reset before its history is trustworthy
   localparam int PRIME_CYCLES = 2;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_t;

endpackage

// File: rtl/gpio_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous pin inputs.
module gpio_sync #(
   parameter int width = 1
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic [width-1:0] d_i,
   output logic [width-1:0] q_o
);

   logic [width-1:0] s1_q, s1_d;
   logic [width-1:0] s2_q, s2_d;

   // Next value of each synchroniser stage
   always_comb begin
      s1_d = d_i;
      s2_d = s1_q;
   end

   // Synchroniser stages, cleared asynchronously
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO input interrupt controller: synchronises pins, latches
// enabled rising/falling edges into a W1C status register and drives a
// masked level interrupt.
//
// Bus state table:
//   state    | meaning
//   BUS_IDLE | no ack pending; a cyc&stb request commits on the next edge
//   BUS_ACK  | wb_ack_o high for this cycle; the next edge always returns to idle
module wb_gpio_irq
   import wb_gpio_irq_pkg::*;
#(
   parameter int n_bits = 32
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   input  logic [4:2]        wb_adr_i,
   input  logic [n_bits-1:0] wb_dat_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic [2:0]        wb_cti_i,
   input  logic [1:0]        wb_bte_i,
   output logic [n_bits-1:0] wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic              wb_rty_o,
   input  logic [n_bits-1:0] gpio_i,
   output logic              irq_o
);

   localparam logic [1:0] PRIME_DONE = 2'(PRIME_CYCLES);

   bus_state_t        state_q, state_d;
   logic [n_bits-1:0] dat_q, dat_d;
   logic [n_bits-1:0] mask_q, mask_d;
   logic [n_bits-1:0] rise_en_q, rise_en_d;
   logic [n_bits-1:0] fall_en_q, fall_en_d;
   logic [n_bits-1:0] status_q, status_d;
   logic [n_bits-1:0] s3_q, s3_d;
   logic [1:0]        prime_q, prime_d;
   logic              primed_q, primed_d;
   logic              irq_q, irq_d;

   logic [n_bits-1:0] s2;
   logic              commit;
   logic              wr_commit;
   logic [n_bits-1:0] rd_mux;
   logic [n_bits-1:0] clr;
   logic [n_bits-1:0] rise_edge;
   logic [n_bits-1:0] fall_edge;
   logic [n_bits-1:0] hit;

   // Burst hints carry no meaning for single-word registers
   logic unused_bus_hints;
   assign unused_bus_hints = ^{wb_cti_i, wb_bte_i};

   gpio_sync #(
      .width (n_bits)
   ) u_sync (
      .clk_sys (wb_clk),
      .rst     (wb_rst),
      .d_i     (gpio_i),
      .q_o     (s2)
   );

   // Ack handshake: one ack per request, never two in consecutive cycles
   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      case (state_q)
         BUS_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               state_d = BUS_ACK;
               commit  = 1'b1;
            end
         end
         BUS_ACK: state_d = BUS_IDLE;
         default: state_d = BUS_IDLE;
      endcase
      wr_commit = commit & wb_we_i;
   end

   // Read-data mux, sampled only on the edge the ack rises
   always_comb begin
      rd_mux = '0;
      case (wb_adr_i)
         REG_IN:     rd_mux = s2;
         REG_MASK:   rd_mux = mask_q;
         REG_RISE:   rd_mux = rise_en_q;
         REG_FALL:   rd_mux = fall_en_q;
         REG_STATUS: rd_mux = status_q;
         default:    rd_mux = '0;
      endcase
      dat_d = commit ? rd_mux : dat_q;
   end

   // Configuration register writes and the status clear vector
   always_comb begin
      mask_d    = mask_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      clr       = '0;
      if (wr_commit) begin
         case (wb_adr_i)
            REG_MASK:   mask_d    = wb_dat_i;
            REG_RISE:   rise_en_d = wb_dat_i;
            REG_FALL:   fall_en_d = wb_dat_i;
            REG_STATUS: clr       = wb_dat_i;
            default:    clr       = '0;
         endcase
      end
   end

   // Edge detection, priming, status latch and interrupt level
   always_comb begin
      s3_d      = s2;
      rise_edge = s2 & ~s3_q;
      fall_edge = ~s2 & s3_q;
      // The enable is registered one cycle behind the counter so that the
      // first edge evaluated already compares s2 against a real copy of it;
      // a pin held high through reset then never looks like a rising edge.
      hit       = primed_q ? ((rise_edge & rise_en_q) | (fall_edge & fall_en_q)) : '0;
      // A new edge wins over a clear of the same bit
      status_d  = (status_q & ~clr) | hit;
      irq_d     = |(status_q & mask_q);
      prime_d   = (prime_q == PRIME_DONE) ? prime_q : prime_q + 2'd1;
      primed_d  = (prime_q == PRIME_DONE);
   end

   // All state, cleared asynchronously by wb_rst
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q   <= BUS_IDLE;
         dat_q     <= '0;
         mask_q    <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         s3_q      <= '0;
         prime_q   <= '0;
         primed_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dat_q     <= dat_d;
         mask_q    <= mask_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         s3_q      <= s3_d;
         prime_q   <= prime_d;
         primed_q  <= primed_d;
         irq_q     <= irq_d;
      end
   end

   assign wb_ack_o = (state_q == BUS_ACK);
   assign wb_dat_o = dat_q;
   assign wb_err_o = 1'b0;
   assign wb_rty_o = 1'b0;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Directed bench for wb_gpio_irq: register table plus timed edge/irq sequences.
module tb_wb_gpio_irq;
   import wb_gpio_irq_pkg::*;

   logic        wb_clk = 1'b0;
   logic        wb_rst = 1'b1;
   logic [2:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o, wb_err_o, wb_rty_o;
   logic [31:0] gpio_i;
   logic        irq_o;

   int   total = 0;
   int   bad   = 0;
   logic irq_at_ack;

   typedef struct {
      logic [2:0]  adr;
      logic        we;
      logic [31:0] wdat;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[19];

   always #5 wb_clk = ~wb_clk;

   wb_gpio_irq #(.n_bits(32)) dut (
      .wb_clk   (wb_clk),
      .wb_rst   (wb_rst),
      .wb_adr_i (wb_adr_i),
      .wb_dat_i (wb_dat_i),
      .wb_we_i  (wb_we_i),
      .wb_cyc_i (wb_cyc_i),
      .wb_stb_i (wb_stb_i),
      .wb_cti_i (wb_cti_i),
      .wb_bte_i (wb_bte_i),
      .wb_dat_o (wb_dat_o),
      .wb_ack_o (wb_ack_o),
      .wb_err_o (wb_err_o),
      .wb_rty_o (wb_rty_o),
      .gpio_i   (gpio_i),
      .irq_o    (irq_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   // One bus access; returns one cycle after the ack edge with the ack low again
   task automatic wb_access(input logic [2:0] adr, input logic we, input logic [31:0] wdat,
                            output logic [31:0] rdat);
      int lat;
      lat = 0;
      @(negedge wb_clk);
      chk1("ack_idle", wb_ack_o, 1'b0);
      wb_adr_i = adr;
      wb_we_i  = we;
      wb_dat_i = wdat;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge wb_clk);
         #1;
         lat++;
         if (wb_ack_o) break;
      end
      chk("ack_latency", 32'(lat), 32'd1);
      chk("err_rty", {30'b0, wb_err_o, wb_rty_o}, 32'd0);
      rdat       = wb_dat_o;
      irq_at_ack = irq_o;
      wb_cyc_i   = 1'b0;
      wb_stb_i   = 1'b0;
      wb_we_i    = 1'b0;
      @(posedge wb_clk);
      #1;
      chk1("ack_drop", wb_ack_o, 1'b0);
   endtask

   task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
      logic [31:0] dummy;
      wb_access(adr, 1'b1, dat, dummy);
   endtask

   task automatic rd_chk(input string name, input logic [2:0] adr, input logic [31:0] exp);
      logic [31:0] d;
      wb_access(adr, 1'b0, 32'h0, d);
      chk(name, d, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge wb_clk);
      #1;
   endtask

   // Release reset with pins already at their final level, enable them at once
   task automatic prime_scenario(input logic [31:0] pins, input logic [31:0] en);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      gpio_i   = pins;
      wb_rst   = 1'b1;
      repeat (3) @(posedge wb_clk);
      #2 wb_rst = 1'b0;
      wr(REG_RISE, en);
      wr(REG_MASK, en);
      for (int i = 0; i < 20; i++) begin
         @(posedge wb_clk);
         #1;
         chk1("prime_irq", irq_o, 1'b0);
      end
      rd_chk("prime_status", REG_STATUS, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [31:0] rd;

      vecs[0]  = '{REG_FALL,   1'b1, 32'h0000_0004, 32'h0};
      vecs[1]  = '{REG_FALL,   1'b0, 32'h0,         32'h0000_0004};
      vecs[2]  = '{REG_RISE,   1'b0, 32'h0,         32'h0000_0001};
      vecs[3]  = '{REG_MASK,   1'b0, 32'h0,         32'h0000_0001};
      vecs[4]  = '{3'd5,       1'b0, 32'h0,         32'h0};
      vecs[5]  = '{3'd6,       1'b1, 32'hFFFF_FFFF, 32'h0};
      vecs[6]  = '{3'd6,       1'b0, 32'h0,         32'h0};
      vecs[7]  = '{3'd7,       1'b1, 32'hFFFF_FFFF, 32'h0};
      vecs[8]  = '{3'd7,       1'b0, 32'h0,         32'h0};
      vecs[9]  = '{REG_MASK,   1'b0, 32'h0,         32'h0000_0001};
      vecs[10] = '{REG_RISE,   1'b0, 32'h0,         32'h0000_0001};
      vecs[11] = '{REG_FALL,   1'b0, 32'h0,         32'h0000_0004};
      vecs[12] = '{REG_STATUS, 1'b0, 32'h0,         32'h0};
      vecs[13] = '{REG_IN,     1'b0, 32'h0,         32'h0000_0001};
      vecs[14] = '{REG_IN,     1'b1, 32'hFFFF_FFFF, 32'h0};
      vecs[15] = '{REG_IN,     1'b0, 32'h0,         32'h0000_0001};
      vecs[16] = '{REG_MASK,   1'b1, 32'h0000_0003, 32'h0};
      vecs[17] = '{REG_MASK,   1'b0, 32'h0,         32'h0000_0003};
      vecs[18] = '{REG_MASK,   1'b1, 32'h0000_0001, 32'h0};

      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_cti_i = '0;
      wb_bte_i = '0;
      gpio_i   = 32'h1;
      irq_at_ack = 1'b0;

      #1;
      chk1("rst_ack", wb_ack_o, 1'b0);
      chk1("rst_irq", irq_o, 1'b0);
      chk("rst_dat", wb_dat_o, 32'h0);
      chk1("rst_err", wb_err_o, 1'b0);

      // Pin high through reset must not look like a rising edge
      prime_scenario(32'h1, 32'h1);

      // Register map table
      for (int i = 0; i < 19; i++) begin
         wb_access(vecs[i].adr, vecs[i].we, vecs[i].wdat, rd);
         if (!vecs[i].we) chk($sformatf("vec%0d", i), rd, vecs[i].exp);
      end

      // Rising edge latency on bit 0
      @(negedge wb_clk) gpio_i = 32'h0;
      cycles(5);
      rd_chk("rise_pre_status", REG_STATUS, 32'h0);
      @(negedge wb_clk) gpio_i = 32'h1;
      @(posedge wb_clk); #1;                                  // edge k
      @(posedge wb_clk); #1; chk1("rise_irq_k1", irq_o, 1'b0);
      @(posedge wb_clk); #1; chk1("rise_irq_k2", irq_o, 1'b0);
      rd_chk("rise_status_k3", REG_STATUS, 32'h1);             // ack on k+3
      chk1("rise_irq_k3", irq_at_ack, 1'b1);
      rd_chk("rise_in", REG_IN, 32'h1);

      // W1C clear drops irq one cycle after the commit
      wr(REG_STATUS, 32'h1);
      chk1("clr_irq_at_commit", irq_at_ack, 1'b1);
      chk1("clr_irq_after", irq_o, 1'b0);
      rd_chk("clr_status", REG_STATUS, 32'h0);

      // Clear and new edge on the same bit in the same cycle: set wins
      @(negedge wb_clk) gpio_i = 32'h0;
      cycles(5);
      @(negedge wb_clk) gpio_i = 32'h1;
      cycles(5);
      rd_chk("sw_pre_status", REG_STATUS, 32'h1);
      chk1("sw_pre_irq", irq_o, 1'b1);
      @(negedge wb_clk) gpio_i = 32'h0;
      cycles(5);
      @(negedge wb_clk) gpio_i = 32'h1;
      @(posedge wb_clk);                                       // edge k
      @(posedge wb_clk);                                       // edge k+1
      wr(REG_STATUS, 32'h1);                                   // commits on k+2
      chk1("sw_irq_at_commit", irq_at_ack, 1'b1);
      chk1("sw_irq_after", irq_o, 1'b1);
      rd_chk("sw_status", REG_STATUS, 32'h1);
      wr(REG_STATUS, 32'h1);
      cycles(2);
      chk1("sw_clr_irq", irq_o, 1'b0);
      rd_chk("sw_clr_status", REG_STATUS, 32'h0);

      // Falling edge on bit 2 latches unmasked; MASK then raises irq
      wr(REG_MASK, 32'h0);
      @(negedge wb_clk) gpio_i = 32'h5;
      cycles(5);
      rd_chk("fall_pre_status", REG_STATUS, 32'h0);
      @(negedge wb_clk) gpio_i = 32'h1;
      cycles(5);
      rd_chk("fall_status", REG_STATUS, 32'h4);
      chk1("fall_irq_masked", irq_o, 1'b0);
      wr(REG_MASK, 32'h4);
      chk1("mask_irq_at_commit", irq_at_ack, 1'b0);
      chk1("mask_irq_after", irq_o, 1'b1);
      wr(REG_FALL, 32'h0);
      rd_chk("fall_en_clear_keeps", REG_STATUS, 32'h4);

      // Build STATUS=0xF with irq high, then reset under a pending strobe
      wr(REG_RISE, 32'hF);
      wr(REG_MASK, 32'hF);
      wr(REG_STATUS, 32'hFFFF_FFFF);
      @(negedge wb_clk) gpio_i = 32'h0;
      cycles(5);
      rd_chk("mr_pre_status", REG_STATUS, 32'h0);
      @(negedge wb_clk) gpio_i = 32'hF;
      cycles(5);
      rd_chk("mr_status", REG_STATUS, 32'hF);
      chk1("mr_irq", irq_o, 1'b1);
      @(negedge wb_clk);
      wb_adr_i = REG_STATUS;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      #2 wb_rst = 1'b1;
      #1;
      chk1("mr_ack", wb_ack_o, 1'b0);
      chk1("mr_irq_rst", irq_o, 1'b0);
      chk("mr_dat", wb_dat_o, 32'h0);
      chk1("mr_err", wb_err_o, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(posedge wb_clk);
         #1;
         chk1("mr_no_ack", wb_ack_o, 1'b0);
      end

      prime_scenario(32'hF, 32'hF);

      // Edge detection works again after priming
      @(negedge wb_clk) gpio_i = 32'h0;
      cycles(4);
      @(negedge wb_clk) gpio_i = 32'hF;
      cycles(5);
      rd_chk("post_status", REG_STATUS, 32'hF);
      chk1("post_irq", irq_o, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
